// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: raster counters, 3x3 column window,
// and a two-stage |Gx|+|Gy| pipeline with saturation to the pixel range.
module sobel_edge #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int DW     = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          sof,
   input  logic [DW-1:0] pixel_in,
   input  logic [DW-1:0] tap1_in,
   input  logic [DW-1:0] tap2_in,
   output logic [DW-1:0] edge_out,
   output logic          edge_valid,
   output logic          frame_done
);

   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int SW = DW + 2;
   localparam int DW3 = DW + 3;

   // Weighted 1-2-1 sum of three pixels; DW+2 bits cannot overflow.
   function automatic logic [SW-1:0] wsum(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
      wsum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   // Absolute difference of two weighted sums via a DW+3 bit signed subtract.
   function automatic logic [SW-1:0] absdiff(input logic [SW-1:0] p,
                                             input logic [SW-1:0] n);
      logic signed [DW3-1:0] d;
      logic signed [DW3-1:0] m;
      d = $signed({1'b0, p}) - $signed({1'b0, n});
      m = -d;
      if (d[DW3-1]) begin
         absdiff = m[SW-1:0];
      end else begin
         absdiff = d[SW-1:0];
      end
   endfunction

   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [CW-1:0] pos_col_s;
   logic [RW-1:0] pos_row_s;
   logic [CW-1:0] nxt_col_s;
   logic [RW-1:0] nxt_row_s;
   logic          win_ok_s;
   logic          win_last_s;

   // win_r[c][k]: c=0 oldest column, c=2 newest; k=0 row r-2, k=2 row r.
   logic [DW-1:0] win_r [3][3];
   logic          win_valid_r;
   logic          win_last_r;

   logic [SW-1:0] gx_s;
   logic [SW-1:0] gy_s;
   logic [SW-1:0] abs_gx_r;
   logic [SW-1:0] abs_gy_r;
   logic          mag_valid_r;
   logic          mag_last_r;
   logic [DW3-1:0] sum_s;
   logic [DW-1:0]  sat_s;

   // Position of the pixel being accepted and the counter value that follows it.
   always_comb begin
      pos_col_s = col_r;
      pos_row_s = row_r;
      nxt_col_s = col_r;
      nxt_row_s = row_r;
      if (sof) begin
         pos_col_s = {CW{1'b0}};
         pos_row_s = {RW{1'b0}};
      end else begin
         pos_col_s = col_r;
         pos_row_s = row_r;
      end
      if (pos_col_s == CW'(WIDTH - 1)) begin
         nxt_col_s = {CW{1'b0}};
         if (pos_row_s == RW'(HEIGHT - 1)) begin
            nxt_row_s = {RW{1'b0}};
         end else begin
            nxt_row_s = pos_row_s + RW'(1);
         end
      end else begin
         nxt_col_s = pos_col_s + CW'(1);
         nxt_row_s = pos_row_s;
      end
      win_ok_s   = (pos_row_s >= RW'(2)) && (pos_col_s >= CW'(2));
      win_last_s = (pos_row_s == RW'(HEIGHT - 1)) && (pos_col_s == CW'(WIDTH - 1));
   end

   // Counters and window advance only on accepted pixels; the valid bit is a pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r       <= {CW{1'b0}};
         row_r       <= {RW{1'b0}};
         win_valid_r <= 1'b0;
         win_last_r  <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 3; k++) begin
               win_r[c][k] <= {DW{1'b0}};
            end
         end
      end else begin
         if (en) begin
            col_r <= nxt_col_s;
            row_r <= nxt_row_s;
            for (int c = 0; c < 2; c++) begin
               for (int k = 0; k < 3; k++) begin
                  win_r[c][k] <= win_r[c+1][k];
               end
            end
            win_r[2][0] <= tap2_in;
            win_r[2][1] <= tap1_in;
            win_r[2][2] <= pixel_in;
         end
         win_valid_r <= en & win_ok_s;
         win_last_r  <= en & win_ok_s & win_last_s;
      end
   end

   // Gradients: Gx = newest column minus oldest, Gy = row r minus row r-2.
   always_comb begin
      gx_s = absdiff(wsum(win_r[2][0], win_r[2][1], win_r[2][2]),
                     wsum(win_r[0][0], win_r[0][1], win_r[0][2]));
      gy_s = absdiff(wsum(win_r[0][2], win_r[1][2], win_r[2][2]),
                     wsum(win_r[0][0], win_r[1][0], win_r[2][0]));
   end

   // Gradient magnitude stage; runs every clock so results drain during en gaps.
   always_ff @(posedge clk) begin
      if (rst) begin
         abs_gx_r    <= {SW{1'b0}};
         abs_gy_r    <= {SW{1'b0}};
         mag_valid_r <= 1'b0;
         mag_last_r  <= 1'b0;
      end else begin
         abs_gx_r    <= gx_s;
         abs_gy_r    <= gy_s;
         mag_valid_r <= win_valid_r;
         mag_last_r  <= win_last_r;
      end
   end

   // Sum and clamp to the largest representable pixel value.
   always_comb begin
      sum_s = {1'b0, abs_gx_r} + {1'b0, abs_gy_r};
      if (sum_s > {3'b000, {DW{1'b1}}}) begin
         sat_s = {DW{1'b1}};
      end else begin
         sat_s = sum_s[DW-1:0];
      end
   end

   // Output register; edge_out keeps its last value between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_out   <= {DW{1'b0}};
         edge_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         edge_valid <= mag_valid_r;
         frame_done <= mag_last_r;
         if (mag_valid_r) begin
            edge_out <= sat_s;
         end
      end
   end

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on an 8x6 frame: table of whole-frame patterns
// plus hand-written reset and mid-frame restart sequences.
module tb_sobel_edge;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst, en, sof;
   logic [DW-1:0] pixel_in, tap1_in, tap2_in, edge_out;
   logic          edge_valid, frame_done;

   sobel_edge #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
      .clk(clk), .rst(rst), .en(en), .sof(sof),
      .pixel_in(pixel_in), .tap1_in(tap1_in), .tap2_in(tap2_in),
      .edge_out(edge_out), .edge_valid(edge_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;
   int dones    = 0;
   logic [DW-1:0] last_out = '0;

   typedef struct {
      logic [DW-1:0] val;
      int            last;
      int            edge_no;
   } exp_t;
   exp_t expq[$];

   typedef struct {
      int pat;       // 0 flat, 1 vertical step, 2 saturation
      bit gaps;      // en toggles every cycle
      int exp_pulses;
      int exp_dones;
   } frame_vec_t;
   frame_vec_t vecs[4];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [DW-1:0] img(input int pat, input int r, input int c);
      case (pat)
         0:       img = 12'h100;
         1:       img = (c < 4) ? 12'h010 : 12'h020;
         2:       img = (r < 3) ? 12'h000 : 12'hFFF;
         default: img = 12'h000;
      endcase
   endfunction

   // Hand-derived result for the window completed by pixel (r,c), centre (r-1,c-1).
   function automatic logic [DW-1:0] exp_val(input int pat, input int r, input int c);
      case (pat)
         0:       exp_val = 12'h000;
         1:       exp_val = ((c - 1) == 3 || (c - 1) == 4) ? 12'h040 : 12'h000;
         2:       exp_val = ((r - 1) == 2 || (r - 1) == 3) ? 12'hFFF : 12'h000;
         default: exp_val = 12'h000;
      endcase
   endfunction

   // Output monitor: matches every pulse against the expectation queue.
   always @(posedge clk) begin
      #1;
      if (rst === 1'b1) begin
         last_out = '0;
      end else if (edge_valid === 1'b1) begin
         pulses++;
         if (frame_done === 1'b1) dones++;
         check("pulse_expected", int'(expq.size() != 0), 1);
         if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            check("edge_out", int'(edge_out), int'(e.val));
            check("frame_done", int'(frame_done), e.last);
            check("latency", cyc - e.edge_no, 2);
         end
         last_out = edge_out;
      end else begin
         check("frame_done_idle", int'(frame_done), 0);
         check("edge_out_hold", int'(edge_out), int'(last_out));
      end
   end

   task automatic drive_pixel(input int pat, input int r, input int c, input bit first);
      @(negedge clk);
      en       = 1'b1;
      sof      = first;
      pixel_in = img(pat, r, c);
      tap1_in  = (r >= 1) ? img(pat, r - 1, c) : 12'h000;
      tap2_in  = (r >= 2) ? img(pat, r - 2, c) : 12'h000;
      if (r >= 2 && c >= 2)
         expq.push_back('{exp_val(pat, r, c), int'(r == H - 1 && c == W - 1), cyc + 1});
   endtask

   // Idle cycles drive sof high so an unqualified sof would corrupt the frame.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         en       = 1'b0;
         sof      = 1'b1;
         pixel_in = 12'hABC;
      end
   endtask

   task automatic run_frame(input int pat, input bit gaps);
      pulses = 0;
      dones  = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gaps) idle(1);
            drive_pixel(pat, r, c, (r == 0 && c == 0));
         end
      end
      idle(4);
   endtask

   initial begin
      vecs[0] = '{0, 1'b0, 24, 1};
      vecs[1] = '{1, 1'b0, 24, 1};
      vecs[2] = '{2, 1'b0, 24, 1};
      vecs[3] = '{1, 1'b1, 24, 1};

      rst = 1'b1; en = 1'b1; sof = 1'b1;
      pixel_in = 12'h123; tap1_in = 12'h456; tap2_in = 12'h789;
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_edge_out", int'(edge_out), 0);
         check("rst_edge_valid", int'(edge_valid), 0);
         check("rst_frame_done", int'(frame_done), 0);
      end
      @(negedge clk);
      rst = 1'b0; en = 1'b0; sof = 1'b0;
      idle(2);

      for (int i = 0; i < 4; i++) begin
         run_frame(vecs[i].pat, vecs[i].gaps);
         check($sformatf("frame%0d_pulses", i), pulses, vecs[i].exp_pulses);
         check($sformatf("frame%0d_dones", i), dones, vecs[i].exp_dones);
         check($sformatf("frame%0d_drained", i), expq.size(), 0);
      end

      // Reset after 20 pixels discards everything in flight.
      for (int i = 0; i < 20; i++) drive_pixel(0, i / W, i % W, (i == 0));
      @(negedge clk);
      rst = 1'b1; en = 1'b1; sof = 1'b1;
      expq.delete();
      @(negedge clk);
      rst = 1'b0; en = 1'b0; sof = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         check("post_reset_valid", int'(edge_valid), 0);
      end
      run_frame(0, 1'b0);
      check("rst_restart_pulses", pulses, 24);
      check("rst_restart_dones", dones, 1);
      check("rst_restart_drained", expq.size(), 0);

      // sof after 20 pixels abandons the frame without a frame_done.
      pulses = 0;
      dones  = 0;
      for (int i = 0; i < 20; i++) drive_pixel(2, i / W, i % W, (i == 0));
      idle(4);
      check("abandoned_pulses", pulses, 2);
      check("abandoned_dones", dones, 0);
      run_frame(1, 1'b0);
      check("sof_restart_pulses", pulses, 24);
      check("sof_restart_dones", dones, 1);
      check("sof_restart_drained", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
